// File: rtl/frame_stream_ctrl.sv
// Drains a read-latency-1 pixel FIFO into a framed, back-pressured stream.
// Col/row/frame counters on both request and return sides; 2-entry skid buffer.
module frame_stream_ctrl #(
  parameter int unsigned DWIDTH = 24,
  parameter int unsigned CW     = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CW-1:0]     width,
  input  logic [CW-1:0]     height,
  input  logic [CW-1:0]     num_frame,
  output logic              fifo_rdreq,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [CW-1:0]     frame_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [CW-1:0]     frm;
    logic              sof;
    logic              eol;
    logic              eof;
    logic [DWIDTH-1:0] data;
  } beat_t;

  state_t        state;
  logic [CW-1:0] w_m1, h_m1, n_m1;
  logic [CW-1:0] rq_col, rq_row, rq_frm;
  logic [CW-1:0] rt_col, rt_row, rt_frm;
  logic          inflight;
  logic [1:0]    occ;
  beat_t         head, tail;
  logic          busy_r, done_r, cfg_err_r;

  logic          fire;
  logic          rd_ok;
  logic          rq_last;
  beat_t         wr_beat;

  always_comb begin
    fire    = (occ != 2'd0) && out_ready;
    // Room check counts the beat leaving this cycle so a full buffer still streams.
    rd_ok   = (state == S_RUN) && !fifo_empty &&
              (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, fire}));
    rq_last = (rq_col == w_m1) && (rq_row == h_m1) && (rq_frm == n_m1);

    wr_beat      = '0;
    wr_beat.data = fifo_data;
    wr_beat.frm  = rt_frm;
    wr_beat.sof  = (rt_col == '0) && (rt_row == '0);
    wr_beat.eol  = (rt_col == w_m1);
    wr_beat.eof  = (rt_col == w_m1) && (rt_row == h_m1);
  end

  assign fifo_rdreq = rd_ok && !reset;
  assign out_valid  = (occ != 2'd0);
  assign out_data   = head.data;
  assign out_sof    = head.sof;
  assign out_eol    = head.eol;
  assign out_eof    = head.eof;
  assign frame_idx  = head.frm;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cfg_err    = cfg_err_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      w_m1      <= '0;
      h_m1      <= '0;
      n_m1      <= '0;
      rq_col    <= '0;
      rq_row    <= '0;
      rq_frm    <= '0;
      rt_col    <= '0;
      rt_row    <= '0;
      rt_frm    <= '0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      head      <= '0;
      tail      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      inflight  <= fifo_rdreq;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (width == '0 || height == '0 || num_frame == '0) begin
              cfg_err_r <= 1'b1;
              done_r    <= 1'b1;
            end else begin
              w_m1   <= width - 1'b1;
              h_m1   <= height - 1'b1;
              n_m1   <= num_frame - 1'b1;
              rq_col <= '0;
              rq_row <= '0;
              rq_frm <= '0;
              rt_col <= '0;
              rt_row <= '0;
              rt_frm <= '0;
              busy_r <= 1'b1;
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (fifo_rdreq) begin
            if (rq_last) begin
              state <= S_DRAIN;
            end else if (rq_col == w_m1) begin
              rq_col <= '0;
              if (rq_row == h_m1) begin
                rq_row <= '0;
                rq_frm <= rq_frm + 1'b1;
              end else begin
                rq_row <= rq_row + 1'b1;
              end
            end else begin
              rq_col <= rq_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Finish as the last beat fires so done lands in the very next cycle.
          if (!inflight && (occ == 2'd0 || (occ == 2'd1 && fire))) begin
            state  <= S_DONE;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (inflight) begin
        if (rt_col == w_m1) begin
          rt_col <= '0;
          if (rt_row == h_m1) begin
            rt_row <= '0;
            rt_frm <= rt_frm + 1'b1;
          end else begin
            rt_row <= rt_row + 1'b1;
          end
        end else begin
          rt_col <= rt_col + 1'b1;
        end
      end

      if (inflight && !fire) begin
        if (occ == 2'd0) head <= wr_beat;
        else             tail <= wr_beat;
        occ <= occ + 2'd1;
      end else if (!inflight && fire) begin
        head <= tail;
        occ  <= occ - 2'd1;
      end else if (inflight && fire) begin
        if (occ == 2'd2) begin
          head <= tail;
          tail <= wr_beat;
        end else begin
          head <= wr_beat;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Bench for frame_stream_ctrl: infinite FIFO source, beat-index stream model, directed jobs.
module tb_frame_stream_ctrl;
  localparam int DW = 24;
  localparam int CW = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] width = '0, height = '0, num_frame = '0;
  logic          fifo_rdreq;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sof, out_eol, out_eof;
  logic [CW-1:0] frame_idx;
  logic          busy, done, cfg_err;

  frame_stream_ctrl #(.DWIDTH(DW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .width(width), .height(height),
    .num_frame(num_frame), .fifo_rdreq(fifo_rdreq), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_idx(frame_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pop_idx = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fdata(input int i);
    logic [31:0] v;
    v = i;
    return {v[7:0] ^ 8'hA5, v[15:0]};
  endfunction

  // Latency-1 FIFO that never runs dry unless the bench raises fifo_empty.
  always @(posedge clock) begin
    if (fifo_rdreq) begin
      fifo_data <= fdata(pop_idx);
      pop_idx   <= pop_idx + 1;
    end
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream model: beat k of a job is FIFO word base+k, markers from k alone.
  int jw, jh, jn, total, base;
  int beat_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int last_fire = -10, start_cyc = 0, first_rd = -1, first_valid = -1;
  bit job_busy = 0, pend = 0, err_pend = 0, rst_chk = 0;
  logic [63:0]   sof_log, eol_log, eof_log, frm_log;
  logic [DW-1:0] dlog [64];

  always @(negedge clock) begin
    int col, row, fr, outst;
    bit exp_done;
    if (reset) begin
      chk(fifo_rdreq == 1'b0, "rdreq_in_reset", fifo_rdreq, 0);
      job_busy = 0; pend = 0; err_pend = 0; rst_chk = 1;
    end else begin
      if (rst_chk) begin
        chk({fifo_rdreq, out_valid, out_sof, out_eol, out_eof, out_data, frame_idx,
             busy, done, cfg_err} == '0, "reset_values",
            {out_valid, busy, done, cfg_err}, 0);
        rst_chk = 0;
      end
      if (pend) begin job_busy = 1; pend = 0; end

      exp_done = err_pend || (job_busy && beat_cnt == total && last_fire == cyc - 1);
      if (done || exp_done) chk(done == exp_done, "done", done, exp_done);
      if (cfg_err || err_pend) chk(cfg_err == err_pend, "cfg_err", cfg_err, err_pend);
      if (done && job_busy) begin
        chk(rd_cnt == total, "read_total", rd_cnt, total);
        done_cnt++;
      end
      if (exp_done) job_busy = 0;
      err_pend = 0;
      chk(busy == job_busy, "busy", busy, job_busy);

      if (fifo_rdreq) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        chk(!fifo_empty, "rdreq_while_empty", fifo_empty, 0);
        chk(job_busy && rd_cnt <= total, "read_outside_job", rd_cnt, total);
        outst = rd_cnt - beat_cnt - ((out_valid && out_ready) ? 1 : 0);
        chk(outst <= 2, "outstanding", outst, 2);
      end

      if (out_valid) begin
        if (!job_busy || beat_cnt >= total) begin
          chk(0, "extra_beat", beat_cnt, total);
        end else begin
          col = beat_cnt % jw;
          row = (beat_cnt / jw) % jh;
          fr  = beat_cnt / (jw * jh);
          if (first_valid < 0) first_valid = cyc;
          chk(out_data == fdata(base + beat_cnt), "data", out_data, fdata(base + beat_cnt));
          chk(out_sof == (col == 0 && row == 0), "sof", out_sof, (col == 0 && row == 0));
          chk(out_eol == (col == jw - 1), "eol", out_eol, (col == jw - 1));
          chk(out_eof == (col == jw - 1 && row == jh - 1), "eof", out_eof,
              (col == jw - 1 && row == jh - 1));
          chk(int'(frame_idx) == fr, "frame_idx", frame_idx, fr);
          if (out_ready) begin
            if (beat_cnt < 64) begin
              sof_log[beat_cnt] = out_sof;
              eol_log[beat_cnt] = out_eol;
              eof_log[beat_cnt] = out_eof;
              frm_log[beat_cnt] = frame_idx[0];
              dlog[beat_cnt]    = out_data;
            end
            beat_cnt++;
            last_fire = cyc;
          end
        end
      end

      if (start && !job_busy && !done && !pend) begin
        if (width == '0 || height == '0 || num_frame == '0) begin
          err_pend = 1;
        end else begin
          pend = 1;
          jw = int'(width); jh = int'(height); jn = int'(num_frame);
          total = jw * jh * jn;
          base = pop_idx;
          beat_cnt = 0; rd_cnt = 0; start_cyc = cyc;
          first_rd = -1; first_valid = -1; last_fire = -10;
          sof_log = '0; eol_log = '0; eof_log = '0; frm_log = '0;
        end
      end
    end
  end

  // Stimulus
  bit rdy_rand = 0;
  int emp_lo = -1, emp_hi = -1, rel = 0;

  task automatic step();
    @(posedge clock);
    #1;
    rel++;
    out_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_empty = (rel >= emp_lo && rel <= emp_hi);
  endtask

  task automatic run_job(input int w, input int h, input int n, input int intr_at);
    int k;
    width = CW'(w); height = CW'(h); num_frame = CW'(n);
    rel = 0;
    fifo_empty = (emp_lo <= 0 && emp_hi >= 0);
    out_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 600 && !done; k++) begin
      if (k == intr_at) begin
        start = 1'b1; width = 11'd2; height = 11'd1; num_frame = 11'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk(done == 1'b1, "done_timeout", done, 1);
    step();
  endtask

  initial begin
    int d0, p0, k;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, k;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    step();

    // 4x2x2, always ready
    d0 = done_cnt;
    run_job(4, 2, 2, -1);
    chk(beat_cnt == 16, "s1_beats", beat_cnt, 16);
    chk(rd_cnt == 16, "s1_reads", rd_cnt, 16);
    chk(sof_log[15:0] == 16'h0101, "s1_sof_mask", sof_log[15:0], 16'h0101);
    chk(eol_log[15:0] == 16'h8888, "s1_eol_mask", eol_log[15:0], 16'h8888);
    chk(eof_log[15:0] == 16'h8080, "s1_eof_mask", eof_log[15:0], 16'h8080);
    chk(frm_log[15:0] == 16'hFF00, "s1_frame_mask", frm_log[15:0], 16'hFF00);
    chk(dlog[0] == 24'hA50000, "s1_first_data", dlog[0], 24'hA50000);
    chk(dlog[15] == 24'hAA000F, "s1_last_data", dlog[15], 24'hAA000F);
    chk(first_rd - start_cyc == 1, "s1_rdreq_latency", first_rd - start_cyc, 1);
    chk(first_valid - start_cyc == 3, "s1_valid_latency", first_valid - start_cyc, 3);
    chk(done_cnt - d0 == 1, "s1_done_count", done_cnt - d0, 1);

    // same job, random back-pressure
    rdy_rand = 1;
    run_job(4, 2, 2, -1);
    rdy_rand = 0;
    out_ready = 1'b1;
    chk(beat_cnt == 16, "s2_beats", beat_cnt, 16);
    chk(eol_log[15:0] == 16'h8888, "s2_eol_mask", eol_log[15:0], 16'h8888);
    chk(eof_log[15:0] == 16'h8080, "s2_eof_mask", eof_log[15:0], 16'h8080);
    chk(dlog[0] == 24'hB50010, "s2_first_data", dlog[0], 24'hB50010);

    // 3x3x1 with FIFO empty in cycles 5-9
    d0 = done_cnt;
    emp_lo = 5; emp_hi = 9;
    run_job(3, 3, 1, -1);
    emp_lo = -1; emp_hi = -1;
    fifo_empty = 1'b0;
    chk(beat_cnt == 9, "s3_beats", beat_cnt, 9);
    chk(sof_log[8:0] == 9'h001, "s3_sof_mask", sof_log[8:0], 9'h001);
    chk(eol_log[8:0] == 9'b100100100, "s3_eol_mask", eol_log[8:0], 9'b100100100);
    chk(eof_log[8:0] == 9'h100, "s3_eof_mask", eof_log[8:0], 9'h100);
    chk(done_cnt - d0 == 1, "s3_done_count", done_cnt - d0, 1);

    // zero width: error pulse, no reads
    p0 = pop_idx;
    width = 11'd0; height = 11'd2; num_frame = 11'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk(cfg_err && done && !busy, "s4_cfg_err_pulse", {cfg_err, done, busy}, 3'b110);
    repeat (4) step();
    chk(!busy && !cfg_err, "s4_idle_after", {busy, cfg_err}, 0);
    chk(pop_idx == p0, "s4_no_reads", pop_idx - p0, 0);

    // second start mid-job is ignored
    run_job(4, 2, 1, 3);
    chk(beat_cnt == 8, "s5_beats", beat_cnt, 8);
    chk(eol_log[7:0] == 8'h88, "s5_eol_mask", eol_log[7:0], 8'h88);
    chk(eof_log[7:0] == 8'h80, "s5_eof_mask", eof_log[7:0], 8'h80);
    repeat (3) step();
    chk(!busy && !out_valid, "s5_quiet_after", {busy, out_valid}, 0);

    // reset after beat 5 of a 4x4x1 job
    width = 11'd4; height = 11'd4; num_frame = 11'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 100 && beat_cnt < 6; k++) step();
    chk(beat_cnt >= 6, "s6_reach_beat5", beat_cnt, 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk({out_valid, busy, done, fifo_rdreq, out_sof, frame_idx, out_data} == '0,
        "s6_after_reset", {out_valid, busy, done, fifo_rdreq}, 0);
    step();
    run_job(2, 2, 1, -1);
    chk(beat_cnt == 4, "s6_beats", beat_cnt, 4);
    chk(sof_log[3:0] == 4'b0001, "s6_sof_mask", sof_log[3:0], 4'b0001);
    chk(eol_log[3:0] == 4'b1010, "s6_eol_mask", eol_log[3:0], 4'b1010);
    chk(eof_log[3:0] == 4'b1000, "s6_eof_mask", eof_log[3:0], 4'b1000);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
